// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst reader for two channel FIFOs; FIFO_BURST_ARB_FLUSH_EN adds timed partial-burst flush.
// First word 3 cycles after GRANT; out_ready low holds the skid head, reads throttle to 2 outstanding words.

module fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_vld,
    input  logic [W-1:0]                 wr_dat,
    input  logic                         rd_rdy,
    output logic                         rd_vld,
    output logic [W-1:0]                 rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, full;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (level == LW'(DEPTH));
    assign rd_vld = (level != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld && rd_rdy;
    assign push   = wr_vld && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module fifo_burst_arbiter #(
    parameter int DATA_W        = 16,
    parameter int CNT_W         = 9,
    parameter int BURST_LEN     = 256,
    parameter int GAP_CYCLES    = 4,
    parameter int FLUSH_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  ch0_count,
    input  logic              ch0_empty,
    output logic              ch0_rdreq,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic [CNT_W-1:0]  ch1_count,
    input  logic              ch1_empty,
    output logic              ch1_rdreq,
    input  logic [DATA_W-1:0] ch1_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              out_ch,
    output logic              busy,
    output logic              underrun_err,
    output logic [15:0]       burst_cnt0,
    output logic [15:0]       burst_cnt1
);
    if (BURST_LEN < 1 || BURST_LEN > (1 << CNT_W) - 1 || FLUSH_TIMEOUT < 1 || FLUSH_TIMEOUT > 65535) begin : g_param_err
        $error("fifo_burst_arbiter: BURST_LEN or FLUSH_TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, BURST, GAP} state_t;
    localparam logic [CNT_W-1:0] BLEN = CNT_W'(BURST_LEN);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   len_q, req_cnt, tx_cnt, grant_len;
    logic [15:0]        gap_cnt;
    logic               rr_ptr, cur_ch, rd_pend;
    logic               full0, full1, elig0, elig1, any_elig, grant_ch;
    logic               sel_empty, rd_want, rd_go, skid_vld, xfer, last_xfer;
    logic [1:0]         skid_lvl;
    logic [2:0]         occ_nxt;
    logic [DATA_W-1:0]  rd_dat;

    assign full0 = enable && (ch0_count >= BLEN) && !ch0_empty;
    assign full1 = enable && (ch1_count >= BLEN) && !ch1_empty;

`ifdef FIFO_BURST_ARB_FLUSH_EN
    localparam logic [15:0] TMO = 16'(FLUSH_TIMEOUT);
    logic [15:0] tmr0, tmr1;
    logic        fl0, fl1, any_full;

    assign fl0 = enable && !ch0_empty && (ch0_count != '0) && (ch0_count < BLEN) && (tmr0 >= TMO);
    assign fl1 = enable && !ch1_empty && (ch1_count != '0) && (ch1_count < BLEN) && (tmr1 >= TMO);
    assign any_full = full0 || full1;
    // A full burst always outranks a flush request.
    assign elig0     = any_full ? full0 : fl0;
    assign elig1     = any_full ? full1 : fl1;
    assign grant_len = any_full ? BLEN : (grant_ch ? ch1_count : ch0_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr0 <= '0;
            tmr1 <= '0;
        end else begin
            if (state == GRANT || ch0_count == '0)
                tmr0 <= '0;
            else if (state == IDLE && enable && ch0_count < BLEN && tmr0 < TMO)
                tmr0 <= tmr0 + 1'b1;
            if (state == GRANT || ch1_count == '0)
                tmr1 <= '0;
            else if (state == IDLE && enable && ch1_count < BLEN && tmr1 < TMO)
                tmr1 <= tmr1 + 1'b1;
        end
    end
`else
    assign elig0     = full0;
    assign elig1     = full1;
    assign grant_len = BLEN;
`endif

    assign any_elig = elig0 || elig1;
    assign grant_ch = (elig0 && elig1) ? ~rr_ptr : elig1;

    // Reads are allowed only while skid words after this cycle's pop plus the in-flight read stay below 2.
    assign occ_nxt   = {1'b0, skid_lvl} + {2'b00, rd_pend} - {2'b00, xfer};
    assign sel_empty = cur_ch ? ch1_empty : ch0_empty;
    assign rd_want   = (state == BURST) && (req_cnt < len_q) && (occ_nxt < 3'd2);
    assign rd_go     = rd_want && !sel_empty;
    assign rd_dat    = cur_ch ? ch1_data : ch0_data;

    fifo #(.W(DATA_W), .DEPTH(2)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (rd_pend),
        .wr_dat (rd_dat),
        .rd_rdy (out_ready),
        .rd_vld (skid_vld),
        .rd_dat (out_data),
        .level  (skid_lvl)
    );

    assign xfer      = skid_vld && out_ready;
    assign last_xfer = xfer && out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any_elig) state_nxt = GRANT;
            GRANT: state_nxt = any_elig ? BURST : IDLE;
            BURST: if (last_xfer) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (gap_cnt == 16'(GAP_CYCLES-1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ch0_rdreq = 1'b0;
        ch1_rdreq = 1'b0;
        busy      = (state != IDLE);
        out_valid = skid_vld;
        out_first = skid_vld && (tx_cnt == '0);
        out_last  = skid_vld && (tx_cnt == len_q - 1'b1);
        out_ch    = cur_ch;
        if (rd_go) begin
            ch0_rdreq = !cur_ch;
            ch1_rdreq = cur_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= 1'b1;
            cur_ch       <= 1'b0;
            len_q        <= BLEN;
            req_cnt      <= '0;
            tx_cnt       <= '0;
            rd_pend      <= 1'b0;
            gap_cnt      <= '0;
            underrun_err <= 1'b0;
            burst_cnt0   <= '0;
            burst_cnt1   <= '0;
        end else begin
            rd_pend <= rd_go;
            if (state == GRANT && any_elig) begin
                cur_ch  <= grant_ch;
                rr_ptr  <= grant_ch;
                len_q   <= grant_len;
                req_cnt <= '0;
                tx_cnt  <= '0;
            end
            if (rd_go)               req_cnt <= req_cnt + 1'b1;
            if (xfer)                tx_cnt  <= tx_cnt + 1'b1;
            if (rd_want && sel_empty) underrun_err <= 1'b1;
            if (last_xfer) begin
                if (cur_ch) burst_cnt1 <= burst_cnt1 + 1'b1;
                else        burst_cnt0 <= burst_cnt0 + 1'b1;
            end
            if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
            else              gap_cnt <= '0;
        end
    end
endmodule

// File: doc/fifo_burst_arbiter.md
Name: fifo_burst_arbiter

Overview:
- Schedules Ethernet readout of the two ADC/convolution channel FIFOs (fifo_acp).
- Grants one channel at a time, round-robin, once that FIFO holds at least BURST_LEN words.
- Reads exactly one burst per grant and streams it to the packetizer over valid/ready, with first/last/channel tags.
- Replaces the direct rdreq1/rdreq2 wiring to Ethernet_module_upper and runs in the FIFO read-clock domain (e_tx_clk).

Parameters:
DATA_W, 16, FIFO word width
CNT_W, 9, width of FIFO rd_data_count
BURST_LEN, 256, words per burst; must be at most 2^CNT_W-1
GAP_CYCLES, 4, minimum idle cycles between bursts
FLUSH_TIMEOUT, 65535, idle cycles before a partial flush (optional feature only)

Ports:
clk  in  1  FIFO read clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new grants
ch0_count  in  CNT_W  rd_data_count of channel 0 FIFO
ch0_empty  in  1  channel 0 FIFO empty
ch0_rdreq  out  1  channel 0 read strobe; data returns one cycle later
ch0_data  in  DATA_W  channel 0 FIFO dout
ch1_count, ch1_empty, ch1_rdreq, ch1_data  as channel 0
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word
out_data  out  DATA_W  output word
out_first  out  1  first word of burst
out_last  out  1  last word of burst
out_ch  out  1  channel of current burst
busy  out  1  state is not IDLE
underrun_err  out  1  sticky: read blocked by empty during a burst
burst_cnt0, burst_cnt1  out  16  completed bursts per channel, wrapping

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0, state IDLE, rr_ptr = 1 so channel 0 wins first, counters 0, skid buffer empty.
- States: IDLE, GRANT, BURST, GAP.
- IDLE:
  - chN eligible = enable && chN_count >= BURST_LEN && !chN_empty.
  - If any channel is eligible, go to GRANT.
- GRANT (1 cycle):
  - One eligible: pick it.
  - Both eligible: pick the channel != rr_ptr.
  - Latch cur_ch, set rr_ptr = cur_ch, clear req_cnt and tx_cnt, go to BURST.
  - out_ch holds cur_ch from GRANT until the next GRANT.
- BURST read side:
  - Assert chX_rdreq (X = cur_ch only) when req_cnt < BURST_LEN, !chX_empty, and skid occupancy + in-flight reads < 2.
  - Each rdreq increments req_cnt.
  - Returned data (one-cycle latency) is written into a 2-entry skid FIFO.
  - No rdreq is ever issued to the non-granted channel.
- BURST output side:
  - out_valid = skid not empty; out_data = skid head.
  - Transfer occurs when out_valid && out_ready; each transfer increments tx_cnt.
  - out_first = 1 when tx_cnt == 0. out_last = 1 when tx_cnt == BURST_LEN-1.
  - out_valid/out_data stay stable while out_ready is low.
  - Sustained throughput is 1 word/cycle with out_ready held high.
- End of burst: on the transfer of out_last, increment burst_cntX (wraps 0xFFFF->0) and go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES = 0, go straight to IDLE.
- Underrun: if chX_empty blocks a required read in BURST, set underrun_err (sticky until reset). Stall and resume when data arrives; the burst length is unchanged.
- enable low mid-burst: the current burst completes in full; no new grant is made.
- Simultaneous eligibility after a burst: the other channel wins, so a channel never takes two consecutive grants while the other is eligible.
- Reset mid-burst: everything clears immediately; no out_last is emitted. Downstream must discard the partial packet.
- Counts compare unsigned; a full CNT_W count is treated as at least BURST_LEN.

Optional Feature:
- Macro FIFO_BURST_ARB_FLUSH_EN.
- Defined:
  - In IDLE, a per-channel idle timer counts while enable && count > 0 && count < BURST_LEN. It resets on any grant or when count returns to 0.
  - When the timer reaches FLUSH_TIMEOUT, that channel is granted a partial burst of length = count latched at GRANT.
  - out_last marks the final word of the partial burst; rr_ptr and burst_cntX update as for a full burst.
  - A full-eligible channel beats a flush-eligible channel.
- Undefined: no timers; a channel below BURST_LEN is never read.

Test Plan:
1. ch0_count = 256, ch1_count = 0, out_ready = 1 -> ch0 granted; 256 words ch0 data 0..255 in order; out_first on word 0, out_last on word 255; burst_cnt0 = 1; ch1_rdreq never high.
2. Both counts = 300, enable held high -> grant order ch0, ch1, ch0, ch1; at least 4 idle cycles between out_last and the next out_first.
3. ch0 burst with out_ready toggling 1-0-1-0 and random 3-cycle stalls -> 256 words, no loss or duplication, data stable during stalls, at most 2 outstanding words.
4. ch0_empty forced high for 10 cycles at word 100 -> underrun_err = 1; output pauses, then the burst completes at exactly 256 words.
5. enable dropped at word 50 of a ch1 burst -> burst finishes at 256; state returns to IDLE with no new grant while both counts = 300.
6. Flush build: ch0_count = 10 held, FLUSH_TIMEOUT = 20 -> after 20 idle cycles a 10-word burst with out_last on word 9; rst_n pulsed low mid-burst -> all outputs 0 that same cycle.
